// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between Writeback and a buffered mul/div result FIFO,
// and tracks pending multi-cycle destinations for Decode hazard stalls.
module rf_write_arbiter #(
  parameter int AWL    = 6,
  parameter int DWL    = 32,
  parameter int STARVE = 4
) (
  input  logic           CLK,
  input  logic           RSTn,
  input  logic           RFWEW,
  input  logic [AWL-2:0] RFAW,
  input  logic [DWL-1:0] ResultW,
  input  logic           MDValid,
  input  logic [AWL-2:0] MDA,
  input  logic [DWL-1:0] MDData,
  output logic           MDReady,
  input  logic           IssueMD,
  input  logic [AWL-2:0] IssueA,
  input  logic [AWL-2:0] RsD,
  input  logic [AWL-2:0] RtD,
  input  logic [AWL-2:0] RdD,
  output logic           StallD,
  output logic           WBHold,
  output logic           RFWE,
  output logic [AWL-2:0] RFWA,
  output logic [DWL-1:0] RFWD
);
  localparam int RW = AWL - 1;
  localparam int NR = 1 << RW;
  logic [1:0]    cnt_q, cnt_d;
  logic          hd_q, hd_d;
  logic [3:0]    st_q, st_d;
  logic [NR-1:0] pend_q, pend_d;
  logic [RW-1:0] addr_q [2];
  logic [DWL-1:0] data_q [2];
  logic          nonempty, fifo_gnt, enq, tail;
  assign nonempty = cnt_q != 2'd0;
  assign MDReady  = cnt_q != 2'd2;
  assign WBHold   = (st_q == 4'(STARVE)) && nonempty;
  assign fifo_gnt = nonempty && (WBHold || !RFWEW);
  assign enq      = MDValid && MDReady;
  assign tail     = hd_q ^ cnt_q[0];
  assign RFWE     = RSTn && (fifo_gnt || RFWEW);
  assign RFWA     = fifo_gnt ? addr_q[hd_q] : RFWEW ? RFAW : '0;
  assign RFWD     = fifo_gnt ? data_q[hd_q] : RFWEW ? ResultW : '0;
  assign StallD   = pend_q[RsD] | pend_q[RtD] | pend_q[RdD];
  assign cnt_d    = cnt_q + {1'b0, enq} - {1'b0, fifo_gnt};
  assign hd_d     = hd_q ^ fifo_gnt;
  // Only a Writeback win with a non-empty FIFO can leave the counter running.
  assign st_d     = (fifo_gnt || !nonempty) ? 4'd0 : st_q + 4'd1;
  always_comb begin
    pend_d = pend_q;
    if (fifo_gnt) pend_d[addr_q[hd_q]] = 1'b0;
    if (IssueMD) pend_d[IssueA] = 1'b1;
    pend_d[0] = 1'b0;
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q     <= '0;
      hd_q      <= 1'b0;
      st_q      <= '0;
      pend_q    <= '0;
      addr_q[0] <= '0;
      addr_q[1] <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hd_q   <= hd_d;
      st_q   <= st_d;
      pend_q <= pend_d;
      if (enq) begin
        addr_q[tail] <= MDA;
        data_q[tail] <= MDData;
      end
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: random and directed stimulus checked every cycle against a queue-based model.
module tb_rf_write_arbiter;
  localparam int STARVE = 4;
  logic        CLK = 0, RSTn = 0;
  logic        RFWEW = 0, MDValid = 0, IssueMD = 0;
  logic [4:0]  RFAW = 0, MDA = 0, IssueA = 0, RsD = 0, RtD = 0, RdD = 0;
  logic [31:0] ResultW = 0, MDData = 0;
  logic        MDReady, StallD, WBHold, RFWE;
  logic [4:0]  RFWA;
  logic [31:0] RFWD;
  int errors = 0, checks = 0;

  rf_write_arbiter #(.AWL(6), .DWL(32), .STARVE(STARVE)) dut (
    .CLK(CLK), .RSTn(RSTn), .RFWEW(RFWEW), .RFAW(RFAW), .ResultW(ResultW),
    .MDValid(MDValid), .MDA(MDA), .MDData(MDData), .MDReady(MDReady),
    .IssueMD(IssueMD), .IssueA(IssueA), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .StallD(StallD), .WBHold(WBHold), .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD));

  always #5 CLK = ~CLK;

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t q[$];
  int   starve = 0;
  bit   pend[32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hold();
    return starve == STARVE && q.size() > 0;
  endfunction
  function automatic bit m_fifo();
    return q.size() > 0 && (m_hold() || !RFWEW);
  endfunction

  task automatic check_model();
    bit fg = m_fifo();
    chk("model RFWE", RFWE, fg || RFWEW);
    chk("model RFWA", RFWA, fg ? q[0].a : RFWEW ? RFAW : 5'd0);
    chk("model RFWD", RFWD, fg ? q[0].d : RFWEW ? ResultW : 32'd0);
    chk("model MDReady", MDReady, q.size() < 2);
    chk("model WBHold", WBHold, m_hold());
    chk("model StallD", StallD, pend[RsD] | pend[RtD] | pend[RdD]);
  endtask

  task automatic update_model();
    bit fg = m_fifo();
    bit acc = MDValid && q.size() < 2;
    int n = q.size();
    ent_t e;
    if (fg) begin
      pend[q[0].a] = 0;
      void'(q.pop_front());
    end
    if (acc) begin
      e.a = MDA; e.d = MDData;
      q.push_back(e);
    end
    starve = (fg || n == 0) ? 0 : starve + 1;
    if (IssueMD && IssueA != 0) pend[IssueA] = 1;
  endtask

  task automatic sample(); @(negedge CLK); check_model(); endtask
  task automatic adv(); @(posedge CLK); update_model(); #1; endtask
  task automatic idle();
    RFWEW = 0; MDValid = 0; IssueMD = 0; RsD = 0; RtD = 0; RdD = 0; IssueA = 0;
  endtask

  initial begin
    foreach (pend[i]) pend[i] = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset RFWE", RFWE, 0);
    chk("reset MDReady", MDReady, 1);
    chk("reset StallD", StallD, 0);
    chk("reset WBHold", WBHold, 0);
    @(negedge CLK); RSTn = 1;
    @(posedge CLK); #1;
    sample(); chk("idle RFWE", RFWE, 0); chk("idle MDReady", MDReady, 1); adv();
    // RAW on a pending multi-cycle destination
    IssueMD = 1; IssueA = 5; sample(); adv();
    IssueMD = 0; RsD = 5; MDValid = 1; MDA = 5; MDData = 32'hDEADBEEF;
    sample(); chk("stall after issue", StallD, 1); adv();
    MDValid = 0;
    sample();
    chk("md RFWE", RFWE, 1); chk("md RFWA", RFWA, 5); chk("md RFWD", RFWD, 32'hDEADBEEF);
    chk("stall in write cycle", StallD, 1); adv();
    sample(); chk("stall released", StallD, 0); adv();
    // starvation: Writeback held busy with two results buffered
    idle(); RFWEW = 1; RFAW = 3; ResultW = 32'h33; MDValid = 1; MDA = 9; MDData = 1;
    sample(); chk("wb wins RFWA", RFWA, 3); adv();
    MDA = 7; MDData = 2; sample(); chk("denied1 hold", WBHold, 0); adv();
    MDValid = 0; sample(); chk("full MDReady", MDReady, 0); chk("denied2 hold", WBHold, 0); adv();
    sample(); chk("denied3 hold", WBHold, 0); adv();
    sample(); chk("denied4 hold", WBHold, 0); chk("denied4 RFWA", RFWA, 3); adv();
    sample(); chk("denied5 hold", WBHold, 1); chk("hold RFWA", RFWA, 9); chk("hold RFWD", RFWD, 1); adv();
    // set and clear of the same register in one cycle: set wins
    RFWEW = 0; IssueMD = 1; IssueA = 7; RsD = 7;
    sample(); chk("drain RFWA", RFWA, 7); chk("pre-set stall", StallD, 0); adv();
    IssueMD = 0; sample(); chk("set wins", StallD, 1); adv();
    // register 0 never pending
    idle(); IssueMD = 1; IssueA = 0; sample(); adv();
    IssueMD = 0; sample(); chk("r0 no stall", StallD, 0); adv();
    // full FIFO: no enqueue in the dequeue cycle, accepted next cycle
    RFWEW = 1; RFAW = 4; MDValid = 1; MDA = 11; MDData = 32'hA; sample(); adv();
    MDA = 12; MDData = 32'hB; sample(); adv();
    RFWEW = 0; MDA = 13; MDData = 32'hC;
    sample(); chk("full deq MDReady", MDReady, 0); chk("full deq RFWA", RFWA, 11); adv();
    sample(); chk("count 1 MDReady", MDReady, 1); chk("deq2 RFWA", RFWA, 12); adv();
    RFWEW = 1; MDA = 14; MDData = 32'hD; sample(); adv();
    // asynchronous reset with two entries queued
    idle(); chk("pre-reset full", MDReady, 0);
    #1 RSTn = 0; #1;
    chk("async MDReady", MDReady, 1); chk("async RFWE", RFWE, 0);
    chk("async StallD", StallD, 0); chk("async WBHold", WBHold, 0);
    q.delete(); starve = 0; foreach (pend[i]) pend[i] = 0;
    @(negedge CLK); RSTn = 1;
    adv();
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      RFWEW = ($urandom % 4) != 0; RFAW = 5'($urandom); ResultW = $urandom;
      MDValid = $urandom % 2; MDA = 5'($urandom % 12); MDData = $urandom;
      IssueMD = ($urandom % 3) == 0; IssueA = 5'($urandom % 12);
      RsD = 5'($urandom % 12); RtD = 5'($urandom % 12); RdD = 5'($urandom % 12);
      sample(); adv();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port between the pipelined Writeback stage and a multi-cycle (mul/div) unit that returns results out of band. It buffers multi-cycle results in a 2-entry FIFO and drains them into idle write-port cycles. It keeps a pending-destination scoreboard that stalls Decode on RAW/WAW hazards. A starvation counter forces a one-cycle Writeback hold so buffered results always retire.

## Interface
Parameters:
- AWL, 6, address parameter shared with the pipeline; register index width is AWL-1 (32 registers at default)
- DWL, 32, data width
- STARVE, 4, consecutive denied cycles with FIFO non-empty before WBHold is asserted (legal range 1..15)

Ports:
- CLK  in  1  clock, all state on rising edge
- RSTn  in  1  asynchronous active-low reset
- RFWEW  in  1  Writeback write request
- RFAW  in  AWL-1  Writeback destination register
- ResultW  in  DWL  Writeback data
- MDValid  in  1  multi-cycle result valid
- MDA  in  AWL-1  multi-cycle destination register
- MDData  in  DWL  multi-cycle result
- MDReady  out  1  FIFO can accept; a transfer occurs when MDValid & MDReady
- IssueMD  in  1  a multi-cycle op leaves Decode this cycle
- IssueA  in  AWL-1  destination of that op
- RsD, RtD, RdD  in  AWL-1 each  Decode source and destination registers
- StallD  out  1  Decode hazard stall
- WBHold  out  1  pipeline must freeze and re-present the same writeback next cycle
- RFWE  out  1  register-file write enable
- RFWA  out  AWL-1  register-file write address
- RFWD  out  DWL  register-file write data

## Operation
- FIFO: 2 entries of {addr, data}, with a 1-bit head pointer and a 2-bit count. MDReady = (count != 2). When full, MDReady stays 0 even if the FIFO dequeues in the same cycle.
- Arbitration (combinational):
  - If WBHold = 1: grant the FIFO head. RFWEW is ignored.
  - Else if RFWEW = 1: grant Writeback (RFWE=1, RFWA=RFAW, RFWD=ResultW).
  - Else if count > 0: grant the FIFO head.
  - Else: RFWE=0, RFWA=0, RFWD=0.
  - A FIFO grant dequeues the head at the clock edge.
- Starvation counter (4 bits):
  - Increments when count > 0 and Writeback wins.
  - Clears when the FIFO is granted or count = 0.
  - WBHold = (counter == STARVE) & (count > 0).
- Scoreboard: pending[31:1]. Bit 0 is hardwired 0.
  - IssueMD sets pending[IssueA].
  - A FIFO grant clears pending[head addr].
  - If a set and a clear hit the same register in the same cycle, the set wins.
- StallD = pending[RsD] | pending[RtD] | pending[RdD]. Evaluated on current state, so a register cleared this cycle stalls Decode this cycle and releases it next cycle.
- Enqueue and dequeue in the same cycle: count is unchanged and the pointers advance.

## Timing
- Reset (RSTn low, asynchronous):
  - Count, head pointer, starvation counter and pending are all cleared.
  - RFWE forced to 0.
  - MDReady = 1, StallD = 0, WBHold = 0.
- Latency:
  - Writeback path: 0 cycles (combinational passthrough).
  - Multi-cycle result: written no earlier than the cycle after it is accepted.
- Pending bit lifetime: set by IssueMD at edge N, so StallD is visible from cycle N+1. It is cleared at the edge ending the cycle in which its result is written.
- Reset asserted mid-operation discards buffered results and pending bits. Upstream is reset alongside.

## Test plan
- Reset, then idle: RFWE=0, MDReady=1, StallD=0, WBHold=0. Pulse RSTn low mid-cycle with 2 entries queued → count=0 and MDReady=1 immediately.
- IssueMD IssueA=5, then RsD=5 → StallD=1 from the next cycle. MDValid MDA=5 MDData=0xDEADBEEF in an idle cycle → RFWE=1, RFWA=5, RFWD=0xDEADBEEF one cycle later. StallD=0 the cycle after that.
- RFWEW held 1 with RFAW=3, and two MD results accepted → MDReady=0 after the second. With STARVE=4, WBHold=1 on the 5th denied cycle → FIFO head written, RFWEW ignored that cycle.
- IssueMD IssueA=7 in the same cycle the FIFO writes register 7 → pending[7] stays 1.
- IssueA=0 → StallD stays 0 for RsD=0.
- FIFO full: dequeue in the same cycle as MDValid=1 → no enqueue (MDReady=0). Count goes 2→1 and the held result is accepted on the next cycle.
